// File: rtl/sign_add_sub.sv
// Registered two's-complement adder/subtractor built from a ripple chain of full adders.
// One-cycle latency, wrap-around result, signed-overflow flag from the MSB carries.
module sign_add_sub #(
   parameter int INPUT_BIT_WIDTH = 8
) (
   input  logic                              Clk,
   input  logic                              Reset,
   input  logic                              AddSubMode,
   input  logic signed [INPUT_BIT_WIDTH-1:0] InputA,
   input  logic signed [INPUT_BIT_WIDTH-1:0] InputB,
   output logic signed [INPUT_BIT_WIDTH-1:0] Result,
   output logic                              Overflow
);

   localparam int N = INPUT_BIT_WIDTH;

   logic        [N-1:0] w_b_cond;
   logic        [N:0]   w_carry;
   logic        [N-1:0] w_sum;
   logic                w_ovf;
   logic signed [N-1:0] r_result_p1;
   logic                r_ovf_p1;

   // Subtract is A + ~B + 1: invert B and inject the +1 as the chain carry-in.
   assign w_b_cond   = InputB ^ {N{~AddSubMode}};
   assign w_carry[0] = ~AddSubMode;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign w_sum[i]     = InputA[i] ^ w_b_cond[i] ^ w_carry[i];
      assign w_carry[i+1] = (InputA[i] & w_b_cond[i]) |
                            (w_carry[i] & (InputA[i] ^ w_b_cond[i]));
   end

   assign w_ovf = w_carry[N] ^ w_carry[N-1];

   // Stage p0 -> p1: output register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_result_p1 <= '0;
         r_ovf_p1    <= 1'b0;
      end else begin
         r_result_p1 <= w_sum;
         r_ovf_p1    <= w_ovf;
      end
   end

   assign Result   = r_result_p1;
   assign Overflow = r_ovf_p1;

endmodule

// File: tb/tb_sign_add_sub.sv
// Directed and model-checked bench for sign_add_sub at the default 8-bit width.
module tb_sign_add_sub;

   logic              Clk;
   logic              Reset;
   logic              AddSubMode;
   logic signed [7:0] InputA;
   logic signed [7:0] InputB;
   logic signed [7:0] Result;
   logic              Overflow;

   int n_checks;
   int n_errors;

   sign_add_sub #(.INPUT_BIT_WIDTH(8)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .AddSubMode(AddSubMode),
      .InputA    (InputA),
      .InputB    (InputB),
      .Result    (Result),
      .Overflow  (Overflow)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%02h expected 0x%02h at %0t", tag, act, exp, $time);
      end
   endtask

   // Drive on the falling edge, sample 1 time unit after the capturing rising edge.
   task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic [7:0] exp_r, input logic exp_o);
      @(negedge Clk);
      InputA     = a;
      InputB     = b;
      AddSubMode = m;
      @(posedge Clk);
      #1;
      chk({tag, "_res"}, Result, exp_r);
      chk({tag, "_ovf"}, {7'd0, Overflow}, {7'd0, exp_o});
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rm;
      int         s;
      logic [7:0] exp_r;
      logic       exp_o;

      n_checks   = 0;
      n_errors   = 0;
      Reset      = 1'b1;
      InputA     = 8'd20;
      InputB     = 8'd8;
      AddSubMode = 1'b1;

      // Outputs held at zero while clocking under reset.
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk);
         #1;
         chk("rst_res", Result, 8'd0);
         chk("rst_ovf", {7'd0, Overflow}, 8'd0);
      end
      // Mid-cycle deassertion must not update the outputs.
      #2;
      Reset = 1'b0;
      #1;
      chk("rst_rel_res", Result, 8'd0);
      @(posedge Clk);
      #1;
      chk("first_res", Result, 8'd28);
      chk("first_ovf", {7'd0, Overflow}, 8'd0);

      apply("add20_8",  8'd20,  8'd8,   1'b1, 8'd28,  1'b0);
      apply("sub20_8",  8'd20,  8'd8,   1'b0, 8'd12,  1'b0);
      apply("add100",   8'd100, 8'd100, 1'b1, 8'hC8,  1'b1);
      apply("sub100",   8'd100, 8'd100, 1'b0, 8'h00,  1'b0);
      apply("add0",     8'd0,   8'd0,   1'b1, 8'h00,  1'b0);
      apply("sub0",     8'd0,   8'd0,   1'b0, 8'h00,  1'b0);
      apply("max_p1",   8'h7F,  8'h01,  1'b1, 8'h80,  1'b1);
      apply("min_m1",   8'h80,  8'h01,  1'b0, 8'h7F,  1'b1);
      apply("m1_p1",    8'hFF,  8'h01,  1'b1, 8'h00,  1'b0);
      apply("m5_mm5",   8'hFB,  8'hFB,  1'b0, 8'h00,  1'b0);
      apply("min_pmin", 8'h80,  8'h80,  1'b1, 8'h00,  1'b1);
      apply("z_mmin",   8'h00,  8'h80,  1'b0, 8'h80,  1'b1);
      apply("m3_p5",    8'hFD,  8'h05,  1'b1, 8'h02,  1'b0);

      // Inputs changing between edges leave the registered value alone.
      #2;
      InputA     = 8'd50;
      InputB     = 8'd9;
      AddSubMode = 1'b0;
      #1;
      chk("hold_res", Result, 8'h02);
      @(posedge Clk);
      #1;
      chk("hold_next", Result, 8'd41);

      // Async reset between edges clears outputs immediately.
      #1;
      Reset = 1'b1;
      #1;
      chk("async_res", Result, 8'd0);
      chk("async_ovf", {7'd0, Overflow}, 8'd0);
      #1;
      Reset = 1'b0;

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rm = 1'($urandom);
         if (rm) s = int'($signed(ra)) + int'($signed(rb));
         else    s = int'($signed(ra)) - int'($signed(rb));
         exp_r = s[7:0];
         exp_o = (s > 127) || (s < -128);
         apply("rand", ra, rb, rm, exp_r, exp_o);
         if ($urandom_range(0, 39) == 0) begin
            #1;
            Reset = 1'b1;
            #1;
            chk("rand_rst_res", Result, 8'd0);
            chk("rand_rst_ovf", {7'd0, Overflow}, 8'd0);
            #1;
            Reset = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
